dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the RV32I core's MEM stage. It is the word-addressed data store that the MEM/WB write-back segment reads and writes. It holds the tag, valid and dirty arrays and sequences line write-back and refill against a word-wide main-memory handshake port. It raises `miss` so the hazard unit can stall the pipeline, and it counts hits and misses for the lab's performance reporting.

## Interface
- `LINE_ADDR_LEN`, 2: log2 of words per line (4 words).
- `SET_ADDR_LEN`, 3: log2 of the number of sets (8 sets).
- Derived: `TAG_ADDR_LEN` = 30 − `LINE_ADDR_LEN` − `SET_ADDR_LEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_rd`  in  1  load request; held by the pipeline while `miss`=1.
- `cpu_wr`  in  1  store request; held by the pipeline while `miss`=1.
- `cpu_addr`  in  32  byte address; bits [1:0] are ignored.
- `cpu_wdata`  in  32  store data, already lane-aligned.
- `cpu_be`  in  4  byte enables for the store.
- `cpu_rdata`  out  32  load data, registered.
- `miss`  out  1  stall request to the hazard unit.
- `mem_req`  out  1  main-memory beat request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_wdata`  out  32  write-beat data.
- `mem_ack`  in  1  beat completion pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read-beat data.
- `hit_cnt`  out  32  number of hits.
- `miss_cnt`  out  32  number of misses.

## Operation
- Address split, high to low: tag, set `[LINE_ADDR_LEN+SET_ADDR_LEN+1 : LINE_ADDR_LEN+2]`, word `[LINE_ADDR_LEN+1:2]`, byte.
- If `cpu_rd` and `cpu_wr` are both high, the request is a write.
- States: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
- IDLE with a request, hit (valid and tag equal):
  - Read: `cpu_rdata` ← word.
  - Write: bytes selected by `cpu_be` are merged into the word, and dirty ← 1.
  - `miss` = 0.
- IDLE with a request, miss:
  - `miss` = 1 combinationally in the same cycle.
  - Next state is SWAP_OUT if the victim line is valid and dirty, otherwise SWAP_IN.
- SWAP_OUT:
  - Issue 2^`LINE_ADDR_LEN` write beats.
  - `mem_addr` = {victim tag, set, beat, 2'b00}, `mem_wdata` = line[beat].
  - The beat counter advances on `mem_ack`.
  - After the last ack, go to SWAP_IN with beat = 0.
- SWAP_IN:
  - Issue read beats at {request tag, set, beat, 2'b00}.
  - On `mem_ack`, line[beat] ← `mem_rdata`.
  - After the last ack, go to SWAP_IN_OK.
- SWAP_IN_OK: tag ← request tag, valid ← 1, dirty ← 0, then go to IDLE. The held request is re-evaluated in IDLE and now hits; a store applies at that point.
- `miss` = 1 in every cycle the state is not IDLE.
- A request dropped or changed mid-miss does not abort the sequence; the refill always completes.
- Counters, both saturating at 2^32−1:
  - `miss_cnt` increments once, on the IDLE→miss transition.
  - `hit_cnt` increments on an IDLE hit, except for the first hit after a refill; a `refilled` flag suppresses that one count.
- Reset:
  - State IDLE, beat counter 0, all valid and dirty bits 0.
  - `cpu_rdata`, `hit_cnt`, `miss_cnt`, `mem_req`, `mem_we` = 0.
  - `miss` = 0.
  - Tag and data arrays are not cleared.
- A reset asserted mid-SWAP_OUT or mid-SWAP_IN abandons the transfer, drops `mem_req` immediately, and leaves no line valid.

## Timing
- Hit load latency: `cpu_rdata` is valid one cycle after the request, matching the existing synchronous DataCache timing.
- Hit store: committed at the clock edge ending the request cycle.
- `mem_req` protocol:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They are held stable from assertion until the cycle `mem_ack` = 1.
  - `mem_req` may stay high into the next beat.
- `mem_ack` received while `mem_req` = 0 is ignored.
- Clean miss with a fixed ack latency L cycles per beat: `miss` stays high for 1 + 4·L + 1 cycles, plus 1 IDLE hit cycle.
- Dirty miss: add 4·L cycles for the write-back.

## Structure
- Package `dcache_pkg`:
  - State enum `dcache_state_t`.
  - Default `LINE_ADDR_LEN` and `SET_ADDR_LEN`.
  - Address-field width localparams.
- Sub-module `dcache_line_array`:
  - Data storage of 2^SET × 2^LINE words.
  - Byte-write port shared by hit stores and refill beats.
  - Asynchronous read of a whole line for write-back; word-select read for loads.
- `dcache_ctrl` owns the tag, valid and dirty bits, the FSM, the beat counter and the counters.

## Test plan
All scenarios use default parameters.
- **Cold read:** after reset, read 0x10.
  - `miss` = 1 in the same cycle.
  - Read beats go to 0x10, 0x14, 0x18, 0x1C; memory returns 0xA0–0xA3.
  - The next hit gives `cpu_rdata` = 0xA0 one cycle later; `miss_cnt` = 1, `hit_cnt` = 0.
- **Partial store:** then write 0x14 with 0xDEADBEEF, `cpu_be` = 4'b0011.
  - `miss` = 0.
  - A read of 0x14 returns 0x0000BEEF; `hit_cnt` = 2.
- **Dirty eviction:** then read 0x90 (same set, tag 1).
  - Write beats to 0x10–0x1C carry 0xA0, 0x0000BEEF, 0xA2, 0xA3.
  - Read beats follow at 0x90–0x9C.
  - `miss_cnt` = 2.
- **Slow memory:** `mem_ack` delayed 5 cycles per beat.
  - `mem_req`, `mem_addr` and `mem_wdata` are stable across the wait.
  - `miss` = 1 throughout.
  - A spurious `mem_ack` sent in IDLE changes nothing.
- **Reset mid-refill:** `rst` asserted after 2 SWAP_IN beats.
  - `mem_req` = 0 and `miss` = 0 immediately.
  - After release, reading 0x10 misses again.
- **Read and write together:** `cpu_rd` = `cpu_wr` = 1 on a hit at 0x18 with data 0x12345678, `cpu_be` = 4'hF.
  - The store is performed.
  - A subsequent read returns 0x12345678.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared state encoding, default geometry and address-field widths for the data cache.
package dcache_pkg;

  localparam int DEF_LINE_ADDR_LEN = 2;
  localparam int DEF_SET_ADDR_LEN  = 3;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BYTE_OFF_LEN = 2;
  localparam int WORD_ADDR_W  = ADDR_W - BYTE_OFF_LEN;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } dcache_state_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Cache data storage: one byte-enabled write port, a word read for loads and a whole-line read for write-back.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
  input  logic                                        clk,
  input  logic                                        wr_en,
  input  logic [SET_ADDR_LEN-1:0]                     wr_set,
  input  logic [LINE_ADDR_LEN-1:0]                    wr_word,
  input  logic [3:0]                                  wr_be,
  input  logic [DATA_W-1:0]                           wr_data,
  input  logic [SET_ADDR_LEN-1:0]                     rd_set,
  input  logic [LINE_ADDR_LEN-1:0]                    rd_word,
  output logic [DATA_W-1:0]                           rd_data,
  input  logic [SET_ADDR_LEN-1:0]                     line_set,
  output logic [(1<<LINE_ADDR_LEN)-1:0][DATA_W-1:0]   line_data
);

  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int WORDS = 1 << LINE_ADDR_LEN;

  logic [DATA_W-1:0] data_mem [SETS*WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_set, wr_word}] <= merge_bytes(data_mem[{wr_set, wr_word}], wr_data, wr_be);
    end
  end

  assign rd_data = data_mem[{rd_set, rd_word}];

  for (genvar w = 0; w < WORDS; w++) begin : g_line
    assign line_data[w] = data_mem[{line_set, LINE_ADDR_LEN'(w)}];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: 1-cycle hit loads, stalls via miss while
// the FSM writes back the dirty victim and refills the line one beat per mem_ack.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int TAG_ADDR_LEN = WORD_ADDR_W - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int WORDS        = 1 << LINE_ADDR_LEN;

  dcache_state_t state;

  logic [TAG_ADDR_LEN-1:0]  req_tag, miss_tag;
  logic [SET_ADDR_LEN-1:0]  req_set, miss_set, line_set;
  logic [LINE_ADDR_LEN-1:0] req_word, beat, beat_nxt;
  logic [TAG_ADDR_LEN-1:0]  tag_arr [SETS];
  logic [SETS-1:0]          valid, dirty;
  logic                     refilled;
  logic                     req, hit, victim_dirty, beat_done;

  logic                     arr_we;
  logic [SET_ADDR_LEN-1:0]  arr_set;
  logic [LINE_ADDR_LEN-1:0] arr_word;
  logic [3:0]               arr_be;
  logic [DATA_W-1:0]        arr_wdata, rd_word_data;
  logic [WORDS-1:0][DATA_W-1:0] line_data;
  logic                     unused_byte_off;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_ADDR_LEN-1:0]  t,
                                                  input logic [SET_ADDR_LEN-1:0]  s,
                                                  input logic [LINE_ADDR_LEN-1:0] b);
    return {t, s, b, {BYTE_OFF_LEN{1'b0}}};
  endfunction

  assign req_word = cpu_addr[LINE_ADDR_LEN+BYTE_OFF_LEN-1 : BYTE_OFF_LEN];
  assign req_set  = cpu_addr[LINE_ADDR_LEN+SET_ADDR_LEN+BYTE_OFF_LEN-1 : LINE_ADDR_LEN+BYTE_OFF_LEN];
  assign req_tag  = cpu_addr[ADDR_W-1 : LINE_ADDR_LEN+SET_ADDR_LEN+BYTE_OFF_LEN];
  assign unused_byte_off = ^cpu_addr[BYTE_OFF_LEN-1:0];

  assign req          = cpu_rd | cpu_wr;
  assign hit          = valid[req_set] && (tag_arr[req_set] == req_tag);
  assign victim_dirty = valid[req_set] && dirty[req_set];
  assign beat_done    = mem_req && mem_ack;
  assign beat_nxt     = beat + 1'b1;
  assign line_set     = (state == IDLE) ? req_set : miss_set;

  // Gated by rst so the stall drops the moment reset is applied, even with a request still held.
  assign miss = !rst && ((state != IDLE) || (req && !hit));

  always_comb begin
    arr_we    = 1'b0;
    arr_set   = req_set;
    arr_word  = req_word;
    arr_be    = cpu_be;
    arr_wdata = cpu_wdata;
    if (state == SWAP_IN) begin
      arr_we    = beat_done;
      arr_set   = miss_set;
      arr_word  = beat;
      arr_be    = 4'hF;
      arr_wdata = mem_rdata;
    end else if (state == IDLE) begin
      arr_we    = cpu_wr && hit;
    end
  end

  dcache_line_array #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .SET_ADDR_LEN  (SET_ADDR_LEN)
  ) u_lines (
    .clk       (clk),
    .wr_en     (arr_we),
    .wr_set    (arr_set),
    .wr_word   (arr_word),
    .wr_be     (arr_be),
    .wr_data   (arr_wdata),
    .rd_set    (req_set),
    .rd_word   (req_word),
    .rd_data   (rd_word_data),
    .line_set  (line_set),
    .line_data (line_data)
  );

  // Tags are never cleared; the valid bits alone decide whether a tag means anything.
  always_ff @(posedge clk) begin
    if (state == SWAP_IN_OK) tag_arr[miss_set] <= miss_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      valid     <= '0;
      dirty     <= '0;
      refilled  <= 1'b0;
      miss_set  <= '0;
      miss_tag  <= '0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (!refilled) hit_cnt <= sat_inc(hit_cnt);
            refilled <= 1'b0;
            if (cpu_wr) dirty[req_set] <= 1'b1;
            else        cpu_rdata      <= rd_word_data;
          end else if (req) begin
            miss_cnt <= sat_inc(miss_cnt);
            miss_set <= req_set;
            miss_tag <= req_tag;
            beat     <= '0;
            mem_req  <= 1'b1;
            if (victim_dirty) begin
              state     <= SWAP_OUT;
              mem_we    <= 1'b1;
              mem_addr  <= beat_addr(tag_arr[req_set], req_set, '0);
              mem_wdata <= line_data[0];
            end else begin
              state     <= SWAP_IN;
              mem_we    <= 1'b0;
              mem_addr  <= beat_addr(req_tag, req_set, '0);
            end
          end
        end
        SWAP_OUT: begin
          if (beat_done) begin
            if (&beat) begin
              state    <= SWAP_IN;
              beat     <= '0;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(miss_tag, miss_set, '0);
            end else begin
              beat      <= beat_nxt;
              mem_addr  <= beat_addr(tag_arr[miss_set], miss_set, beat_nxt);
              mem_wdata <= line_data[beat_nxt];
            end
          end
        end
        SWAP_IN: begin
          if (beat_done) begin
            if (&beat) begin
              state   <= SWAP_IN_OK;
              beat    <= '0;
              mem_req <= 1'b0;
            end else begin
              beat     <= beat_nxt;
              mem_addr <= beat_addr(miss_tag, miss_set, beat_nxt);
            end
          end
        end
        SWAP_IN_OK: begin
          valid[miss_set] <= 1'b1;
          dirty[miss_set] <= 1'b0;
          refilled        <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses push expected beats/load data, negedge monitors compare.
module tb_dcache_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t       exp_beat [$];
  logic [31:0] exp_rd   [$];
  logic [31:0] mem_model [logic [31:0]];
  int          lat      = 1;
  logic        spurious = 1'b0;

  logic        rd_pend = 1'b0;
  logic        st_pend = 1'b0;
  logic [64:0] st_prev = '0;

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main memory: acks each beat after lat cycles of mem_req, or pulses ack on demand while idle.
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (spurious) begin
        mem_ack = 1'b1;
      end else if (mem_req && !rst) begin
        if (wait_cnt >= lat - 1) begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hBAD0_0000;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] e;
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdata_unexpected: got %0h with no load outstanding", cpu_rdata);
      end else begin
        e = exp_rd.pop_front();
        cmp("rdata", cpu_rdata, e);
      end
    end
    rd_pend = cpu_rd && !cpu_wr && !miss && !rst;

    if (mem_req && mem_ack) begin
      if (exp_beat.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_unexpected: got we=%0b addr=%0h", mem_we, mem_addr);
      end else begin
        b = exp_beat.pop_front();
        cmp("beat_addr", {mem_we, mem_addr}, {b.we, b.addr});
        if (b.we) cmp("beat_wdata", mem_wdata, b.wdata);
      end
    end

    if (st_pend && !rst) cmp("req_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, st_prev});
    st_pend = mem_req && !mem_ack && !rst;
    st_prev = {mem_we, mem_addr, mem_wdata};
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic first_miss, output int miss_cycles);
    int n;
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(negedge clk);
    first_miss = miss;
    n = 0;
    while (miss && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (miss) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: addr %0h still missing after %0d cycles", addr, n);
    end
    miss_cycles = n;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic push_line(input logic we, input logic [31:0] base,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    exp_beat.push_back('{we: we, addr: base,        wdata: d0});
    exp_beat.push_back('{we: we, addr: base + 32'h4, wdata: d1});
    exp_beat.push_back('{we: we, addr: base + 32'h8, wdata: d2});
    exp_beat.push_back('{we: we, addr: base + 32'hC, wdata: d3});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic fm;
    int   mc;
    int   n;
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    for (int i = 0; i < 4; i++) begin
      mem_model[32'h010 + 4*i] = 32'hA0 + i;
      mem_model[32'h090 + 4*i] = 32'hB0 + i;
      mem_model[32'h110 + 4*i] = 32'hC0 + i;
    end
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_miss", miss, 0);
    cmp("rst_mem_req", mem_req, 0);
    cmp("rst_mem_we", mem_we, 0);
    cmp("rst_rdata", cpu_rdata, 0);
    cmp("rst_hit_cnt", hit_cnt, 0);
    cmp("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;

    // Cold read of 0x10: clean refill, fixed latency 1.
    push_line(1'b0, 32'h10, 0, 0, 0, 0);
    exp_rd.push_back(32'hA0);
    access(1, 0, 32'h10, 0, 0, fm, mc);
    cmp("cold_first_miss", fm, 1);
    cmp("cold_miss_cycles", mc, 6);
    cmp("cold_hit_cnt", hit_cnt, 0);
    cmp("cold_miss_cnt", miss_cnt, 1);

    // Partial store to 0x14, then read it back.
    access(0, 1, 32'h14, 32'hDEADBEEF, 4'b0011, fm, mc);
    cmp("pstore_miss", fm, 0);
    cmp("pstore_hit_cnt", hit_cnt, 1);
    exp_rd.push_back(32'h0000BEEF);
    access(1, 0, 32'h14, 0, 0, fm, mc);
    cmp("pread_miss", fm, 0);
    cmp("pread_hit_cnt", hit_cnt, 2);

    // Dirty eviction by 0x90 (same set, tag 1).
    push_line(1'b1, 32'h10, 32'hA0, 32'h0000BEEF, 32'hA2, 32'hA3);
    push_line(1'b0, 32'h90, 0, 0, 0, 0);
    exp_rd.push_back(32'hB0);
    access(1, 0, 32'h90, 0, 0, fm, mc);
    cmp("dirty_first_miss", fm, 1);
    cmp("dirty_miss_cycles", mc, 10);
    cmp("dirty_miss_cnt", miss_cnt, 2);
    cmp("dirty_hit_cnt", hit_cnt, 2);

    // Slow memory: dirty the 0x90 line, then evict it with 5-cycle beats.
    access(0, 1, 32'h90, 32'h55AA55AA, 4'hF, fm, mc);
    cmp("slow_store_hit_cnt", hit_cnt, 3);
    lat = 5;
    push_line(1'b1, 32'h90, 32'h55AA55AA, 32'hB1, 32'hB2, 32'hB3);
    push_line(1'b0, 32'h110, 0, 0, 0, 0);
    exp_rd.push_back(32'hC0);
    access(1, 0, 32'h110, 0, 0, fm, mc);
    cmp("slow_first_miss", fm, 1);
    cmp("slow_miss_cycles", mc, 42);
    cmp("slow_miss_cnt", miss_cnt, 3);

    // Spurious ack while idle must be ignored.
    @(posedge clk); #2;
    spurious = 1'b1;
    @(posedge clk); #2;
    spurious = 1'b0;
    @(posedge clk); #2;
    cmp("spur_mem_req", mem_req, 0);
    cmp("spur_miss", miss, 0);
    cmp("spur_hit_cnt", hit_cnt, 3);
    cmp("spur_miss_cnt", miss_cnt, 3);
    lat = 1;
    exp_rd.push_back(32'hC1);
    access(1, 0, 32'h114, 0, 0, fm, mc);
    cmp("spur_read_miss", fm, 0);
    cmp("spur_read_hit_cnt", hit_cnt, 4);

    // Reset after two refill beats of a clean miss on 0x10.
    lat = 3;
    exp_beat.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
    exp_beat.push_back('{we: 1'b0, addr: 32'h14, wdata: 32'h0});
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 32'h10;
    n = 0;
    while (exp_beat.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_beat.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rstmid_timeout: %0d beats outstanding", exp_beat.size());
      exp_beat.delete();
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    cmp("rstmid_mem_req", mem_req, 0);
    cmp("rstmid_miss", miss, 0);
    cmp("rstmid_miss_cnt", miss_cnt, 0);
    cpu_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    push_line(1'b0, 32'h10, 0, 0, 0, 0);
    exp_rd.push_back(32'hA0);
    access(1, 0, 32'h10, 0, 0, fm, mc);
    cmp("rstmid_remiss", fm, 1);
    cmp("rstmid_miss_cycles", mc, 6);
    cmp("rstmid_miss_cnt2", miss_cnt, 1);
    cmp("rstmid_hit_cnt", hit_cnt, 0);

    // Read and write together on a hit is a store.
    access(1, 1, 32'h18, 32'h12345678, 4'hF, fm, mc);
    cmp("rw_miss", fm, 0);
    cmp("rw_rdata_kept", cpu_rdata, 32'hA0);
    cmp("rw_hit_cnt", hit_cnt, 1);
    exp_rd.push_back(32'h12345678);
    access(1, 0, 32'h18, 0, 0, fm, mc);
    cmp("rw_read_hit_cnt", hit_cnt, 2);

    repeat (3) @(negedge clk);
    cmp("beats_left", exp_beat.size(), 0);
    cmp("loads_left", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
